ramio_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the single RAMIO port (cache-backed RAM plus UART/LED I/O).
- Master 0 is instruction fetch, read-only in practice. Master 1 is data load/store.
- Grants one master at a time, registers its request, holds the downstream port stable until completion, then returns read data and a done pulse.
- Includes a watchdog so a hung PSRAM access cannot lock the core.

---
 rtl/ramio_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_ramio_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ramio_arbiter.sv
// ramio_arbiter: two-master arbiter and sequencer for the single RAMIO port.
// Optional: define RAMIO_ARBITER_ROUND_ROBIN_EN for round-robin on contention.
module ramio_arbiter #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 4096,
    parameter int TIMEOUT_BITWIDTH = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        m0_req,
    input  logic [1:0]                  m0_write_type,
    input  logic [2:0]                  m0_read_type,
    input  logic [ADDRESS_BITWIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0]       m0_data_in,
    output logic                        m0_done,
    output logic                        m0_error,

    input  logic                        m1_req,
    input  logic [1:0]                  m1_write_type,
    input  logic [2:0]                  m1_read_type,
    input  logic [ADDRESS_BITWIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0]       m1_data_in,
    output logic                        m1_done,
    output logic                        m1_error,

    output logic [DATA_WIDTH-1:0]       rdata,

    output logic                        ram_enable,
    output logic [1:0]                  ram_write_type,
    output logic [2:0]                  ram_read_type,
    output logic [ADDRESS_BITWIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]       ram_data_in,
    input  logic [DATA_WIDTH-1:0]       ram_data_out,
    input  logic                        ram_data_out_ready,
    input  logic                        ram_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_BITWIDTH-1:0] TMO_LAST =
        TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

    state_t                        r_state;
    state_t                        w_state_nx;
    logic                          r_gnt;
    logic                          w_gnt_nx;
    logic                          r_en;
    logic                          w_en_nx;
    logic [1:0]                    r_wt;
    logic [1:0]                    w_wt_nx;
    logic [2:0]                    r_rt;
    logic [2:0]                    w_rt_nx;
    logic [ADDRESS_BITWIDTH-1:0]   r_addr;
    logic [ADDRESS_BITWIDTH-1:0]   w_addr_nx;
    logic [DATA_WIDTH-1:0]         r_din;
    logic [DATA_WIDTH-1:0]         w_din_nx;
    logic [DATA_WIDTH-1:0]         r_rdata;
    logic [DATA_WIDTH-1:0]         w_rdata_nx;
    logic                          r_done0;
    logic                          w_done0_nx;
    logic                          r_done1;
    logic                          w_done1_nx;
    logic                          r_err0;
    logic                          w_err0_nx;
    logic                          r_err1;
    logic                          w_err1_nx;
    logic [TIMEOUT_BITWIDTH-1:0]   r_cnt;
    logic [TIMEOUT_BITWIDTH-1:0]   w_cnt_nx;

    logic w_req0;
    logic w_req1;
    logic w_any;
    logic w_pick1;
    logic w_is_read;
    logic w_cmp;
    logic w_tmo;

    // The master whose done is showing this cycle re-requests one cycle later.
    assign w_req0 = m0_req & ~r_done0;
    assign w_req1 = m1_req & ~r_done1;
    assign w_any  = w_req0 | w_req1;

`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
    logic r_last;
    logic w_last_nx;

    // On contention grant whoever did not win last time.
    assign w_pick1 = (w_req0 & w_req1) ? ~r_last : w_req1;
`else
    // Fixed priority: fetch always beats load/store.
    assign w_pick1 = ~w_req0 & w_req1;
`endif

    assign w_is_read = |r_rt[1:0];
    assign w_cmp     = ~ram_busy & (~w_is_read | ram_data_out_ready);
    assign w_tmo     = WD_EN & (r_cnt == TMO_LAST);

    // Next-state and next-register logic for the sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_en_nx    = r_en;
        w_wt_nx    = r_wt;
        w_rt_nx    = r_rt;
        w_addr_nx  = r_addr;
        w_din_nx   = r_din;
        w_rdata_nx = r_rdata;
        w_done0_nx = 1'b0;
        w_done1_nx = 1'b0;
        w_err0_nx  = 1'b0;
        w_err1_nx  = 1'b0;
        w_cnt_nx   = r_cnt;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
        w_last_nx  = r_last;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_nx   = w_pick1;
                    w_en_nx    = 1'b1;
                    w_wt_nx    = w_pick1 ? m1_write_type : m0_write_type;
                    w_rt_nx    = w_pick1 ? m1_read_type  : m0_read_type;
                    w_addr_nx  = w_pick1 ? m1_address    : m0_address;
                    w_din_nx   = w_pick1 ? m1_data_in    : m0_data_in;
                    w_state_nx = S_ISSUE;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
                    w_last_nx  = w_pick1;
`endif
                end
            end
            S_ISSUE: begin
                w_cnt_nx   = '0;
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (w_cmp || w_tmo) begin
                    w_en_nx    = 1'b0;
                    w_wt_nx    = 2'b00;
                    w_rt_nx    = 3'b000;
                    w_done0_nx = ~r_gnt;
                    w_done1_nx = r_gnt;
                    w_state_nx = S_IDLE;
                    if (w_cmp) begin
                        if (w_is_read) begin
                            w_rdata_nx = ram_data_out;
                        end
                    end else begin
                        w_rdata_nx = '0;
                        w_err0_nx  = ~r_gnt;
                        w_err1_nx  = r_gnt;
                    end
                end else if (r_cnt != '1) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and all output-driving registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_en    <= 1'b0;
            r_wt    <= 2'b00;
            r_rt    <= 3'b000;
            r_addr  <= '0;
            r_din   <= '0;
            r_rdata <= '0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_en    <= w_en_nx;
            r_wt    <= w_wt_nx;
            r_rt    <= w_rt_nx;
            r_addr  <= w_addr_nx;
            r_din   <= w_din_nx;
            r_rdata <= w_rdata_nx;
            r_done0 <= w_done0_nx;
            r_done1 <= w_done1_nx;
            r_err0  <= w_err0_nx;
            r_err1  <= w_err1_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
    // Last-grant pointer starts at master 1 so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_last_nx;
        end
    end
`endif

    assign m0_done        = r_done0;
    assign m1_done        = r_done1;
    assign m0_error       = r_err0;
    assign m1_error       = r_err1;
    assign rdata          = r_rdata;
    assign ram_enable     = r_en;
    assign ram_write_type = r_wt;
    assign ram_read_type  = r_rt;
    assign ram_address    = r_addr;
    assign ram_data_in    = r_din;

endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter: random two-master traffic against a transaction-level model.
// Watchdog shortened to 16 cycles so timeouts occur within the run.
`timescale 1ns/1ps
module tb_ramio_arbiter;

    localparam int T   = 16;
    localparam int TBW = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        t_req [2];
    logic [1:0]  t_wt  [2];
    logic [2:0]  t_rt  [2];
    logic [31:0] t_a   [2];
    logic [31:0] t_d   [2];
    bit          infl  [2];
    int          gap   [2];

    logic        m0_done, m0_error, m1_done, m1_error;
    logic [31:0] rdata;
    logic        ram_enable;
    logic [1:0]  ram_write_type;
    logic [2:0]  ram_read_type;
    logic [31:0] ram_address, ram_data_in;
    logic [31:0] ram_data_out = '0;
    logic        ram_data_out_ready = 1'b0;
    logic        ram_busy = 1'b0;

    always #5 clk = ~clk;

    ramio_arbiter #(
        .ADDRESS_BITWIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_BITWIDTH(TBW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m0_req(t_req[0]),
        .m0_write_type(t_wt[0]),
        .m0_read_type(t_rt[0]),
        .m0_address(t_a[0]),
        .m0_data_in(t_d[0]),
        .m0_done(m0_done),
        .m0_error(m0_error),
        .m1_req(t_req[1]),
        .m1_write_type(t_wt[1]),
        .m1_read_type(t_rt[1]),
        .m1_address(t_a[1]),
        .m1_data_in(t_d[1]),
        .m1_done(m1_done),
        .m1_error(m1_error),
        .rdata(rdata),
        .ram_enable(ram_enable),
        .ram_write_type(ram_write_type),
        .ram_read_type(ram_read_type),
        .ram_address(ram_address),
        .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out),
        .ram_data_out_ready(ram_data_out_ready),
        .ram_busy(ram_busy)
    );

    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_req(input int m);
        t_a[m]   = $urandom;
        t_d[m]   = $urandom;
        t_wt[m]  = 2'($urandom_range(0, 3));
        t_rt[m]  = 3'($urandom_range(0, 7));
        t_req[m] = 1'b1;
    endtask

    // Model of the transaction in flight
    bit          act;
    bit          fin;
    bit          el0, el1;
    bit          g_err;
    int          g_id;
    int          e, G, dedge, Lb, Lr, C, k, i;
    logic [31:0] g_a, g_d, rd_exp;
    logic [1:0]  g_wt;
    logic [2:0]  g_rt;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
    bit          last;
`endif

    initial begin
        for (int m = 0; m < 2; m++) begin
            t_req[m] = 1'b0;
            t_wt[m]  = '0;
            t_rt[m]  = '0;
            t_a[m]   = '0;
            t_d[m]   = '0;
            infl[m]  = 1'b0;
            gap[m]   = int'($urandom_range(0, 3));
        end
        act    = 1'b0;
        g_id   = 0;
        g_err  = 1'b0;
        rd_exp = '0;
        e      = 0;
        G      = 0;
        dedge  = 0;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
        last   = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("reset_port", 64'({ram_enable, ram_write_type, ram_read_type,
                               ram_address, m0_done, m0_error,
                               m1_done, m1_error}), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            e++;
            fin = act && (e == dedge);
            if (fin) begin
                if (g_err) rd_exp = '0;
                else if (g_rt[1:0] != 2'b00) rd_exp = ram_data_out;
            end

            if (act && !fin) begin
                chk("port", 64'({ram_enable, ram_write_type, ram_read_type}),
                    64'({1'b1, g_wt, g_rt}));
                chk("addr", 64'(ram_address), 64'(g_a));
                chk("din", 64'(ram_data_in), 64'(g_d));
            end else begin
                chk("port_idle",
                    64'({ram_enable, ram_write_type, ram_read_type}), 64'd0);
            end
            chk("done_err", 64'({m0_done, m0_error, m1_done, m1_error}),
                !fin ? 64'd0 :
                (g_id == 0) ? 64'({1'b1, g_err, 2'b00}) :
                              64'({2'b00, 1'b1, g_err}));
            chk("rdata", 64'(rdata), 64'(rd_exp));

            // Masters: hold req until done, sometimes drop it mid-access,
            // sometimes keep it high past done as a fresh request.
            if (fin) begin
                act = 1'b0;
                infl[g_id] = 1'b0;
                if ($urandom_range(0, 3) != 0) begin
                    t_req[g_id] = 1'b0;
                    gap[g_id] = int'($urandom_range(0, 3));
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (!(fin && m == g_id)) begin
                    if (infl[m]) begin
                        if (t_req[m] && $urandom_range(0, 9) == 0)
                            t_req[m] = 1'b0;
                    end else if (!t_req[m]) begin
                        if (gap[m] == 0) new_req(m);
                        else gap[m]--;
                    end
                end
            end

            // Arbitration at the next edge
            if (!act) begin
                el0 = t_req[0] && !(fin && g_id == 0);
                el1 = t_req[1] && !(fin && g_id == 1);
                if (el0 || el1) begin
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
                    if (el0 && el1) g_id = last ? 0 : 1;
                    else g_id = el0 ? 0 : 1;
                    last = (g_id == 1);
`else
                    g_id = el0 ? 0 : 1;
`endif
                    act = 1'b1;
                    infl[g_id] = 1'b1;
                    G = e + 1;
                    g_a  = t_a[g_id];
                    g_d  = t_d[g_id];
                    g_wt = t_wt[g_id];
                    g_rt = t_rt[g_id];
                    k = int'($urandom_range(0, 9));
                    if (k < 6)       Lb = int'($urandom_range(0, 3));
                    else if (k == 6) Lb = T - 1;
                    else if (k == 7) Lb = T;
                    else if (k == 8) Lb = T + 5;
                    else             Lb = 0;
                    if (g_rt[1:0] != 2'b00) begin
                        if (k == 9) Lr = int'($urandom_range(2, 17));
                        else        Lr = int'($urandom_range(0, 3));
                        C = (Lb > Lr) ? Lb : Lr;
                    end else begin
                        Lr = 40;
                        C = Lb;
                    end
                    g_err = (C >= T);
                    dedge = G + 2 + (g_err ? T - 1 : C);
                end
            end

            // RAMIO model: stale-looking idle status during ISSUE.
            if (act && (e + 1) >= G + 2) begin
                i = e + 1 - G - 2;
                ram_busy = (i < Lb);
                ram_data_out_ready = (i >= Lr);
            end else if (act) begin
                ram_busy = 1'b0;
                ram_data_out_ready = 1'b1;
            end else begin
                ram_busy = 1'($urandom_range(0, 1));
                ram_data_out_ready = 1'($urandom_range(0, 1));
            end
            ram_data_out = $urandom;
        end

        // Drain, then reset in the middle of a stuck access.
        t_req[0] = 1'b0;
        t_req[1] = 1'b0;
        ram_busy = 1'b0;
        ram_data_out_ready = 1'b1;
        repeat (25) @(negedge clk);
        t_a[0]  = 32'h0000_1234;
        t_wt[0] = 2'b00;
        t_rt[0] = 3'b010;
        t_req[0] = 1'b1;
        ram_busy = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst", 64'({ram_enable, ram_read_type}), 64'({1'b1, 3'b010}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({ram_enable, ram_write_type, ram_read_type,
                              m0_done, m0_error, m1_done, m1_error}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        t_a[1]  = 32'h0000_5678;
        t_rt[1] = 3'b111;
        t_req[1] = 1'b1;
        ram_busy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 64'({ram_enable, ram_address}),
            64'({1'b1, 32'h0000_1234}));

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
